// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the RAM/I-O responder: I/O window base, register
// offsets and the address bits that select the I/O window.
package ram_io_responder_pkg;

    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [2:0]  IO_DATA_OFS = 3'd0;
    localparam logic [2:0]  IO_STAT_OFS = 3'd4;

    localparam int unsigned IO_SEL_HI = 17;
    localparam int unsigned IO_SEL_LO = 16;

    // True when the byte address falls in the I/O window.
    function automatic logic is_io(input logic [31:0] a);
        return a[IO_SEL_HI:IO_SEL_LO] == IO_BASE[IO_SEL_HI:IO_SEL_LO];
    endfunction

endpackage

// File: rtl/ram_io_responder_fifo.sv
// Byte FIFO used for both the TX and RX directions of the I/O window.
// Ports: clk, rst (sync, active-high), push/din, pop, dout (head byte),
//        empty, full, count (occupancy, log2(DEPTH)+1 bits).
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty = (cnt == CW'(0));
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    // Status is sampled before this cycle's transfers.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers and occupancy; pointer wrap is the natural PW-bit rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-wide memory responder for the CPU RAM port: synchronous byte RAM
// plus an I/O window with TX/RX FIFOs toward the host, a status register
// and a sticky halt latch.
// Ports: clk, rst (sync, active-high); mem_a/mem_din/mem_wr request,
//        mem_dout registered read byte; io_full (TX almost full);
//        tx_data/tx_valid/tx_ready host TX stream; rx_data/rx_valid/
//        rx_ready host RX stream; halt (sticky stop request).
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter string       INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_din,
    input  logic        mem_wr,
    output logic [7:0]  mem_dout,
    output logic        io_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt
);

    localparam int unsigned RAM_BYTES = 2 ** ADDR_WIDTH;
    localparam int unsigned FIFO_CW   = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]            ram [RAM_BYTES];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  io_sel;
    logic [2:0]            io_ofs;

    logic                  tx_push, tx_pop, tx_empty, tx_full;
    logic [FIFO_CW-1:0]    tx_count;
    logic                  rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]            rx_head;
    logic [FIFO_CW-1:0]    rx_count_unused;
    logic                  unused_addr;

    // Address decode.
    assign io_sel      = is_io(mem_a);
    assign io_ofs      = mem_a[2:0];
    assign ram_idx     = mem_a[ADDR_WIDTH-1:0];
    assign unused_addr = ^mem_a;

    assign tx_push = io_sel &&  mem_wr && (io_ofs == IO_DATA_OFS);
    assign rx_pop  = io_sel && !mem_wr && (io_ofs == IO_DATA_OFS);
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_push = rx_valid && rx_ready;

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full && !rst;
    // Two spare TX slots absorb bytes already in flight while the CPU stalls.
    assign io_full  = (tx_count >= FIFO_CW'(FIFO_DEPTH - 2));

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (mem_din),
        .pop   (tx_pop),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (rx_data),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count_unused)
    );

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_wr && !io_sel) ram[ram_idx] <= mem_din;
    end

    // Read data register; held across write cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_dout <= 8'h00;
        end else if (!mem_wr) begin
            if (io_sel) begin
                case (io_ofs)
                    IO_DATA_OFS: mem_dout <= rx_empty ? 8'h00 : rx_head;
                    IO_STAT_OFS: mem_dout <= {6'b0, tx_full, !rx_empty};
                    default:     mem_dout <= 8'h00;
                endcase
            end else begin
                mem_dout <= ram[ram_idx];
            end
        end
    end

    // Sticky halt latch, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt <= 1'b0;
        end else if (io_sel && mem_wr && (io_ofs == IO_STAT_OFS)) begin
            halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder.
module tb_ram_io_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_a = 32'h0;
    logic [7:0]  mem_din = 8'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout;
    logic        io_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        halt;

    int n_cmp = 0;
    int n_bad = 0;

    ram_io_responder dut (
        .clk      (clk),
        .rst      (rst),
        .mem_a    (mem_a),
        .mem_din  (mem_din),
        .mem_wr   (mem_wr),
        .mem_dout (mem_dout),
        .io_full  (io_full),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .halt     (halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_wr = 1'b0;
        mem_a  = 32'h0000_0000;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_din = d; mem_wr = 1'b1;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        mem_a = a; mem_wr = 1'b0;
        cyc();
        idle();
    endtask

    logic [7:0] exp_b [4];
    logic [7:0] drained [$];

    initial begin
        exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12;

        // Reset state
        cyc(); cyc();
        chk("rst_dout",     32'(mem_dout), 32'h00);
        chk("rst_halt",     32'(halt),     32'h0);
        chk("rst_txvalid",  32'(tx_valid), 32'h0);
        chk("rst_iofull",   32'(io_full),  32'h0);
        chk("rst_rxready",  32'(rx_ready), 32'h0);
        rst = 1'b0;
        cyc();
        chk("rxready_after_rst", 32'(rx_ready), 32'h1);

        // Single RAM write/read, and write cycles hold mem_dout
        wr(32'h10, 8'hA5);
        rd(32'h10);
        chk("ram_rd_10", 32'(mem_dout), 32'hA5);
        wr(32'h20, 8'h11);
        chk("dout_held_on_wr", 32'(mem_dout), 32'hA5);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(i), exp_b[i]);
        for (int i = 0; i < 4; i++) begin
            mem_a = 32'h100 + 32'(i); mem_wr = 1'b0;
            cyc();
            chk($sformatf("b2b_rd_%0d", i), 32'(mem_dout), 32'(exp_b[i]));
        end
        idle();

        // TX ordering
        wr(32'h30000, 8'h48);
        wr(32'h30000, 8'h69);
        chk("tx_valid_q", 32'(tx_valid), 32'h1);
        chk("tx_head_48", 32'(tx_data),  32'h48);
        tx_ready = 1'b1;
        cyc();
        chk("tx_head_69",   32'(tx_data),  32'h69);
        chk("tx_valid_one", 32'(tx_valid), 32'h1);
        cyc();
        chk("tx_drained", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

        // TX almost-full threshold, overflow drop, full drain
        for (int i = 0; i < 9; i++) begin
            wr(32'h30000, 8'h10 + 8'(i));
            if (i == 4) chk("iofull_after5", 32'(io_full), 32'h0);
            if (i == 5) chk("iofull_after6", 32'(io_full), 32'h1);
        end
        rd(32'h30004);
        chk("stat_txfull", 32'(mem_dout), 32'h02);
        tx_ready = 1'b1;
        drained.delete();
        for (int c = 0; c < 20; c++) begin
            if (!tx_valid) break;
            drained.push_back(tx_data);
            cyc();
        end
        tx_ready = 1'b0;
        chk("drain_count", 32'(drained.size()), 32'd8);
        for (int i = 0; i < drained.size() && i < 8; i++)
            chk($sformatf("drain_%0d", i), 32'(drained[i]), 32'h10 + 32'(i));
        chk("iofull_empty", 32'(io_full), 32'h0);

        // RX path
        rx_data = 8'h41; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        rd(32'h30004);
        chk("stat_rx1",   32'(mem_dout), 32'h01);
        rd(32'h30000);
        chk("rx_pop_41",  32'(mem_dout), 32'h41);
        rd(32'h30000);
        chk("rx_empty_rd", 32'(mem_dout), 32'h00);
        rd(32'h30004);
        chk("stat_rx0",   32'(mem_dout), 32'h00);

        // Empty-read in the same cycle as a host push keeps the byte
        rx_data = 8'h5A; rx_valid = 1'b1;
        mem_a = 32'h30000; mem_wr = 1'b0;
        cyc();
        rx_valid = 1'b0; idle();
        chk("rx_race_rd", 32'(mem_dout), 32'h00);
        rd(32'h30000);
        chk("rx_race_kept", 32'(mem_dout), 32'h5A);

        // RX fill to full, then read back in order
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'hC0 + 8'(i); rx_valid = 1'b1;
            cyc();
        end
        rx_valid = 1'b0;
        chk("rx_full_ready", 32'(rx_ready), 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd(32'h30000);
            chk($sformatf("rx_rd_%0d", i), 32'(mem_dout), 32'hC0 + 32'(i));
        end
        chk("rx_ready_again", 32'(rx_ready), 32'h1);

        // Unmapped I/O reads zero
        rd(32'h30002);
        chk("unmapped_rd", 32'(mem_dout), 32'h00);

        // Halt latch
        wr(32'h30004, 8'h00);
        chk("halt_set", 32'(halt), 32'h1);
        cyc(); cyc(); cyc();
        chk("halt_sticky", 32'(halt), 32'h1);

        // Reset with TX queued; RAM retained and write during reset ignored
        for (int i = 0; i < 3; i++) wr(32'h30000, 8'hE0 + 8'(i));
        rd(32'h10);
        chk("pre_rst_dout", 32'(mem_dout), 32'hA5);
        chk("pre_rst_txv",  32'(tx_valid), 32'h1);
        rst = 1'b1;
        mem_a = 32'h10; mem_din = 8'hFF; mem_wr = 1'b1;
        cyc();
        idle();
        chk("rst2_txvalid", 32'(tx_valid), 32'h0);
        chk("rst2_halt",    32'(halt),     32'h0);
        chk("rst2_dout",    32'(mem_dout), 32'h00);
        chk("rst2_rxready", 32'(rx_ready), 32'h0);
        rst = 1'b0;
        cyc();
        rd(32'h10);
        chk("ram_retained", 32'(mem_dout), 32'hA5);
        chk("tx_empty_post", 32'(tx_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
